// File: rtl/mc_port_scheduler.sv
// Single-port memory scheduler shared by the read and write arbiters. It also
// tracks announced stores against issued ones to gate the kernel-end handshake.
module mc_port_scheduler #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CTRL    = 1,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_req_valid_i,
    output logic                            rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]           rd_addr_i,
    input  logic                            wr_req_valid_i,
    output logic                            wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]           wr_addr_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic [NUM_CTRL-1:0]             ctrl_valid_i,
    output logic [NUM_CTRL-1:0]             ctrl_ready_o,
    input  logic [NUM_CTRL*COUNT_WIDTH-1:0] ctrl_count_i,
    input  logic                            end_valid_i,
    output logic                            end_ready_o,
    output logic                            mem_end_valid_o,
    input  logic                            mem_end_ready_i,
    output logic                            mem_en_o,
    output logic                            mem_we_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o
);
    localparam int PW = COUNT_WIDTH + $clog2(NUM_CTRL + 1) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e               state_q, state_d;
    logic                 last_wr_q, last_wr_d;
    logic signed [PW-1:0] pending_q, pending_d;
    logic                 rd_inflight_q;

    logic                 active, rd_grant, wr_grant, tok_any;
    logic [PW-1:0]        tok_sum;

    // Reset gates everything combinationally so nothing leaks out while rst is high.
    always_comb begin
        active   = !rst && (state_q != DONE);
        rd_grant = active && rd_req_valid_i && (!wr_req_valid_i || last_wr_q);
        wr_grant = active && wr_req_valid_i && !rd_grant;
    end

    always_comb begin
        tok_sum = '0;
        tok_any = 1'b0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (active && ctrl_valid_i[i]) begin
                tok_sum = tok_sum + {{(PW-COUNT_WIDTH){1'b0}}, ctrl_count_i[i*COUNT_WIDTH +: COUNT_WIDTH]};
                tok_any = 1'b1;
            end
        end
        pending_d = pending_q + $signed(tok_sum) - $signed({{(PW-1){1'b0}}, wr_grant});
        last_wr_d = wr_grant ? 1'b1 : (rd_grant ? 1'b0 : last_wr_q);
    end

    always_comb begin
        state_d         = state_q;
        end_ready_o     = 1'b0;
        mem_end_valid_o = 1'b0;
        case (state_q)
            RUN:   if (end_valid_i) state_d = DRAIN;
            // Quiescent: no store owed, nothing issuing, and the last load's data is back.
            DRAIN: if (pending_d == '0 && !tok_any && !rd_grant && !wr_grant && !rd_inflight_q)
                       state_d = DONE;
            DONE: begin
                mem_end_valid_o = !rst;
                if (mem_end_ready_i && !rst) begin
                    end_ready_o = 1'b1;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            last_wr_q     <= 1'b1;
            pending_q     <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_wr_q     <= last_wr_d;
            pending_q     <= pending_d;
            rd_inflight_q <= rd_grant;
        end
    end

    assign rd_req_ready_o = rd_grant;
    assign wr_req_ready_o = wr_grant;
    assign ctrl_ready_o   = {NUM_CTRL{active}};
    assign mem_en_o       = rd_grant | wr_grant;
    assign mem_we_o       = wr_grant;
    assign mem_addr_o     = wr_grant ? wr_addr_i : (rd_grant ? rd_addr_i : '0);
    assign mem_wdata_o    = wr_data_i;

endmodule

// File: tb/tb_mc_port_scheduler.sv
// Bench for mc_port_scheduler: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural model.
module tb_mc_port_scheduler;
    localparam int AW = 32, DW = 32, NC = 2, CW = 8;

    logic          clk = 0, rst = 1;
    logic          rd_v = 0, wr_v = 0, end_valid = 0, mem_end_ready = 0;
    logic [AW-1:0] rd_addr = 0, wr_addr = 0;
    logic [DW-1:0] wr_data = 0;
    logic [NC-1:0] ctrl_valid = 0;
    logic [NC*CW-1:0] ctrl_count = 0;
    logic          rd_ready, wr_ready, end_ready, mem_end_valid, mem_en, mem_we;
    logic [NC-1:0] ctrl_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int tests = 0, fails = 0, n_ends = 0;

    // Behavioural model: phase 0=running, 1=waiting for quiescence, 2=end offered
    int     m_phase = 0;
    longint m_pend = 0;
    bit     m_last_wr = 1, m_rd_prev = 0, m_end_ack = 0;

    mc_port_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CTRL(NC), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid_i(rd_v), .rd_req_ready_o(rd_ready), .rd_addr_i(rd_addr),
        .wr_req_valid_i(wr_v), .wr_req_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready), .ctrl_count_i(ctrl_count),
        .end_valid_i(end_valid), .end_ready_o(end_ready),
        .mem_end_valid_o(mem_end_valid), .mem_end_ready_i(mem_end_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare and model advance; inputs are stable from negedge to posedge.
    always @(negedge clk) begin
        bit     act, erg, ewg, tok;
        longint tsum, pn;
        logic [71:0] e_v, a_v;
        a_v = {rd_ready, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, ctrl_ready, end_ready, mem_end_valid};
        if (rst) begin
            e_v = {4'b0, 32'h0, wr_data, 2'b00, 2'b00};
            m_phase = 0; m_pend = 0; m_last_wr = 1; m_rd_prev = 0;
        end else begin
            act  = (m_phase != 2);
            erg  = act && rd_v && (!wr_v || m_last_wr);
            ewg  = act && wr_v && !erg;
            tsum = 0;
            tok  = 0;
            for (int i = 0; i < NC; i++)
                if (act && ctrl_valid[i]) begin
                    tsum += longint'(ctrl_count[i*CW +: CW]);
                    tok = 1;
                end
            e_v = {erg, ewg, erg | ewg, ewg, ewg ? wr_addr : (erg ? rd_addr : 32'h0), wr_data,
                   act ? 2'b11 : 2'b00, (m_phase == 2) && mem_end_ready, m_phase == 2};
            pn = m_pend + tsum - longint'(ewg);
            case (m_phase)
                0: if (end_valid) m_phase = 1;
                1: if (pn == 0 && !tok && !erg && !ewg && !m_rd_prev) m_phase = 2;
                default: if (mem_end_ready) begin m_phase = 0; m_end_ack = 1; n_ends++; end
            endcase
            m_pend = pn;
            if (erg) m_last_wr = 0; else if (ewg) m_last_wr = 1;
            m_rd_prev = erg;
        end
        tests++;
        if (a_v !== e_v) begin
            fails++;
            $display("FAIL cycle_outputs: got %h expected %h at %0t", a_v, e_v, $time);
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic idle();
        rd_v = 0; wr_v = 0; ctrl_valid = 0; ctrl_count = 0; end_valid = 0; mem_end_ready = 0;
    endtask
    task automatic do_reset();
        rst = 1; idle(); repeat (2) @(posedge clk); #1; rst = 0;
    endtask

    initial begin
        int rst_cnt;
        longint nc;
        #2;
        chk("reset_en", mem_en, 0);
        chk("reset_ctrl_ready", ctrl_ready, 0);
        do_reset();

        // Round-robin with both requesters held: R,W,R,W,R,W
        rd_v = 1; wr_v = 1; rd_addr = 32'h20; wr_addr = 32'h30;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_we", mem_we, (i % 2));
            chk("rr_rd_ready", rd_ready, (i % 2) == 0);
            cyc();
        end
        chk("model_last_wr", m_last_wr, 1);

        idle(); wr_v = 1; wr_addr = 32'h10; wr_data = 32'hAB;
        @(negedge clk);
        chk("wr_only_en", mem_en, 1);
        chk("wr_only_we", mem_we, 1);
        chk("wr_only_addr", mem_addr, 32'h10);
        chk("wr_only_wdata", mem_wdata, 32'hAB);
        cyc();

        // Token of 3, three stores, end raised after the first store
        do_reset();
        ctrl_valid = 2'b01; ctrl_count = 16'h0003;
        @(negedge clk); chk("tok_ready", ctrl_ready, 2'b11); cyc();
        ctrl_valid = 0; wr_v = 1;
        @(negedge clk); chk("st1_grant", wr_ready, 1); cyc();
        end_valid = 1;
        @(negedge clk); chk("st2_mev", mem_end_valid, 0); cyc();
        @(negedge clk); chk("st3_mev", mem_end_valid, 0); chk("st3_grant", wr_ready, 1); cyc();
        wr_v = 0;
        @(negedge clk); chk("after_st3_mev", mem_end_valid, 0); cyc();
        rd_v = 1;
        @(negedge clk);
        chk("done_mev", mem_end_valid, 1);
        chk("done_blocks_rd", rd_ready, 0);
        chk("done_ctrl_ready", ctrl_ready, 0);
        chk("model_pend_done", m_pend, 0);
        cyc();
        rd_v = 0; mem_end_ready = 1;
        @(negedge clk); chk("end_ready", end_ready, 1); cyc();
        end_valid = 0; mem_end_ready = 0; m_end_ack = 0;
        @(negedge clk); chk("back_to_run_mev", mem_end_valid, 0); cyc();

        // Store before its token: pending dips to -1 then returns to 0
        do_reset();
        wr_v = 1; cyc();
        wr_v = 0; ctrl_valid = 2'b01; ctrl_count = 16'h0001; end_valid = 1; cyc();
        ctrl_valid = 0;
        @(negedge clk); chk("neg_pend_mev0", mem_end_valid, 0); cyc();
        mem_end_ready = 1;
        @(negedge clk);
        chk("neg_pend_mev1", mem_end_valid, 1);
        chk("neg_pend_end_ready", end_ready, 1);
        cyc();
        idle(); m_end_ack = 0;

        // Last read in DRAIN: quiescence waits for its data to return
        do_reset();
        end_valid = 1; cyc();
        rd_v = 1;
        @(negedge clk); chk("last_rd_grant", rd_ready, 1); cyc();
        rd_v = 0;
        @(negedge clk); chk("rd_n1_mev", mem_end_valid, 0); cyc();
        @(negedge clk); chk("rd_n2_mev", mem_end_valid, 0); cyc();
        mem_end_ready = 1;
        @(negedge clk); chk("rd_n3_mev", mem_end_valid, 1); cyc();
        idle(); m_end_ack = 0;

        // Reset during DRAIN with pending=2 discards the count
        do_reset();
        ctrl_valid = 2'b01; ctrl_count = 16'h0002; end_valid = 1; cyc();
        ctrl_valid = 0; cyc();
        rd_v = 1; wr_v = 1; rst = 1;
        @(negedge clk);
        chk("rst_en", mem_en, 0);
        chk("rst_grants", {rd_ready, wr_ready}, 0);
        chk("rst_ctrl_end", {ctrl_ready, end_ready, mem_end_valid}, 0);
        cyc();
        rst = 0; rd_v = 0; wr_v = 0;
        @(negedge clk); chk("post_rst_ctrl_ready", ctrl_ready, 2'b11); cyc();
        @(negedge clk); chk("post_rst_mev0", mem_end_valid, 0); cyc();
        mem_end_ready = 1;
        @(negedge clk);
        chk("post_rst_mev1", mem_end_valid, 1);
        chk("post_rst_end_ready", end_ready, 1);
        cyc();
        idle(); m_end_ack = 0;

        // Randomized traffic; drives towards quiescence while draining
        rst_cnt = 0;
        n_ends = 0;
        for (int k = 0; k < 4000; k++) begin
            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom % 500 == 0) rst_cnt = 2;
            rst = (rst_cnt > 0);
            if (m_end_ack) begin end_valid = 0; m_end_ack = 0; end
            else if (!end_valid && $urandom % 25 == 0) end_valid = 1;
            rd_addr = $urandom; wr_addr = $urandom; wr_data = $urandom;
            mem_end_ready = ($urandom % 3 == 0);
            if (m_phase == 1) begin
                rd_v = ($urandom % 4 == 0);
                ctrl_valid = 0; ctrl_count = 0; wr_v = 0;
                if (m_pend > 0) wr_v = 1;
                else if (m_pend < 0) begin
                    nc = (-m_pend > 255) ? 255 : -m_pend;
                    ctrl_valid = 2'b01;
                    ctrl_count = {8'd0, 8'(nc)};
                end
            end else begin
                rd_v = $urandom % 2;
                wr_v = $urandom % 2;
                ctrl_valid = {($urandom % 8 == 0), ($urandom % 8 == 0)};
                ctrl_count = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
            end
            cyc();
        end
        rst = 0;
        tests++;
        if (n_ends == 0) begin
            fails++;
            $display("FAIL random_end_handshakes: got %0d expected >0", n_ends);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
